// File: rtl/window_buffer_3x3.sv
// 3x3 sliding window over a raster-order pixel stream.
// Two line buffers hold the previous rows; a 3x3 register window shifts one
// column per accepted pixel and is exposed on rd_data with zero read latency.
module window_buffer_3x3 #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int IMG_WIDTH     = 16,
    parameter int IMG_HEIGHT    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [ELEMENT_WIDTH-1:0]   in_data,
    input  logic [8:0]                 rd_en,
    output logic [9*ELEMENT_WIDTH-1:0] rd_data,
    output logic                       win_valid,
    output logic                       frame_done,
    output logic                       rd_err
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]         col;
    logic [COL_W-1:0]         cur_col;
    logic [ROW_W-1:0]         row;
    logic [ROW_W-1:0]         cur_row;
    logic [ELEMENT_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [ELEMENT_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [ELEMENT_WIDTH-1:0] lb0_rd;
    logic [ELEMENT_WIDTH-1:0] lb1_rd;
    logic [ELEMENT_WIDTH-1:0] w [3][3];

    // Position of the incoming pixel; start-of-frame forces it to (0,0).
    always_comb begin
        cur_col = col;
        cur_row = row;
        if (in_sof) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    assign lb0_rd = lb0[cur_col];
    assign lb1_rd = lb1[cur_col];

    // Raster position counters plus the window-valid and frame-done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (in_valid) begin
            win_valid  <= (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            frame_done <= (cur_row == LAST_ROW) && (cur_col == LAST_COL);
            if (cur_col == LAST_COL) begin
                col <= '0;
                row <= (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

    // Shift the window left by one column and load the new right-hand column.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    w[i][j] <= '0;
                end
            end
        end else if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
                w[i][0] <= w[i][1];
                w[i][1] <= w[i][2];
            end
            w[0][2] <= lb1_rd;
            w[1][2] <= lb0_rd;
            w[2][2] <= in_data;
        end
    end

    // Line buffers are left unreset; rows 0-1 of each frame never raise
    // win_valid, so stale contents can never reach a valid window.
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            lb1[cur_col] <= lb0_rd;
            lb0[cur_col] <= in_data;
        end
    end

    // Sticky flag for a consumer reading taps while no valid window exists.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_err <= 1'b0;
        end else if ((rd_en != 9'd0) && !win_valid) begin
            rd_err <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        for (genvar gj = 0; gj < 3; gj++) begin : g_col
            assign rd_data[(3*gi+gj)*ELEMENT_WIDTH +: ELEMENT_WIDTH] = w[gi][gj];
        end
    end

endmodule

// File: tb/tb_window_buffer_3x3.sv
// Directed testbench for window_buffer_3x3 on a 4x4 image, with a positional
// reference model feeding a scoreboard of expected per-cycle outputs.
module tb_window_buffer_3x3;

    localparam int EW = 32;
    localparam int IW = 4;
    localparam int IH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_sof;
    logic [EW-1:0]   in_data;
    logic [8:0]      rd_en;
    logic [9*EW-1:0] rd_data;
    logic            win_valid;
    logic            frame_done;
    logic            rd_err;

    typedef struct packed {
        logic            accepted;
        logic            chk_taps;
        logic            valid;
        logic            done;
        logic            err;
        logic [9*EW-1:0] taps;
    } exp_t;

    exp_t sb[$];

    int              m_row;
    int              m_col;
    logic [EW-1:0]   img [IH][IW];
    logic            m_valid;
    logic            m_done;
    logic            m_err;
    logic [9*EW-1:0] m_taps;

    int check_count = 0;
    int pass_count = 0;
    int valid_windows = 0;

    window_buffer_3x3 #(
        .ELEMENT_WIDTH(EW),
        .IMG_WIDTH(IW),
        .IMG_HEIGHT(IH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_sof(in_sof),
        .in_data(in_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .win_valid(win_valid),
        .frame_done(frame_done),
        .rd_err(rd_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkBit(input string tag, input logic obs, input logic expv);
        check_count++;
        assert (obs === expv) pass_count++;
        else $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    endtask

    task automatic checkWide(input string tag, input logic [9*EW-1:0] obs,
                             input logic [9*EW-1:0] expv);
        check_count++;
        assert (obs === expv) pass_count++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            check_count++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        checkBit("win_valid", win_valid, e.valid);
        checkBit("frame_done", frame_done, e.done);
        checkBit("rd_err", rd_err, e.err);
        if (e.chk_taps) checkWide("taps", rd_data, e.taps);
        if (e.accepted && win_valid === 1'b1) valid_windows++;
    endtask

    task automatic applyStimulus(input logic v, input logic sof,
                                 input logic [EW-1:0] d, input logic [8:0] re);
        exp_t e;
        int   r;
        int   c;
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        rd_en    = re;
        m_err = m_err | ((re != 9'd0) && !m_valid);
        if (v) begin
            r = sof ? 0 : m_row;
            c = sof ? 0 : m_col;
            img[r][c] = d;
            m_valid = (r >= 2) && (c >= 2);
            m_done  = (r == IH-1) && (c == IW-1);
            if (m_valid) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        m_taps[(3*i+j)*EW +: EW] = img[r-2+i][c-2+j];
            end
            if (c == IW-1) begin
                m_col = 0;
                m_row = (r == IH-1) ? 0 : r + 1;
            end else begin
                m_col = c + 1;
                m_row = r;
            end
        end else begin
            m_done = 1'b0;
        end
        e.accepted = v;
        e.chk_taps = m_valid;
        e.valid    = m_valid;
        e.done     = m_done;
        e.err      = m_err;
        e.taps     = m_taps;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Reset with a pixel and read enables present, which reset must override.
    task automatic doReset();
        exp_t e;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = 77;
        rd_en    = 9'h1FF;
        m_row = 0;
        m_col = 0;
        m_valid = 1'b0;
        m_done = 1'b0;
        m_err = 1'b0;
        m_taps = '0;
        e.accepted = 1'b0;
        e.chk_taps = 1'b1;
        e.valid    = 1'b0;
        e.done     = 1'b0;
        e.err      = 1'b0;
        e.taps     = '0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
        rst      = 1'b0;
        in_valid = 1'b0;
        rd_en    = 9'd0;
    endtask

    // Read enables only while the model says a valid window is presented.
    function automatic logic [8:0] legalRead();
        return m_valid ? 9'h1FF : 9'd0;
    endfunction

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_data = '0;
        rd_en = 9'd0;
        m_row = 0;
        m_col = 0;
        m_valid = 1'b0;
        m_done = 1'b0;
        m_err = 1'b0;
        m_taps = '0;
        repeat (2) @(posedge clk);

        doReset();

        $display("[TB] illegal read right after reset, then continuous frame");
        applyStimulus(1'b0, 1'b0, '0, 9'h1FF);
        valid_windows = 0;
        for (int p = 0; p < 16; p++) begin
            applyStimulus(1'b1, 1'b0, EW'(p), 9'd0);
            if (p == 10)
                checkWide("p10_taps", rd_data,
                          {32'd10, 32'd9, 32'd8, 32'd6, 32'd5, 32'd4, 32'd2, 32'd1, 32'd0});
        end
        checkWide("valid_windows", (9*EW)'(valid_windows), (9*EW)'(4));
        applyStimulus(1'b0, 1'b0, '0, 9'd0);

        $display("[TB] bubbles after pixel 10, legal reads, back-to-back frame");
        doReset();
        for (int p = 0; p < 16; p++) begin
            applyStimulus(1'b1, 1'b0, EW'(p), legalRead());
            if (p == 10)
                for (int b = 0; b < 3; b++)
                    applyStimulus(1'b0, 1'b0, EW'(999), legalRead());
        end
        for (int p = 0; p < 16; p++) begin
            applyStimulus(1'b1, 1'b0, EW'(p + 100), legalRead());
            if (p == 10)
                checkWide("f2_first_taps", rd_data,
                          {32'd110, 32'd109, 32'd108, 32'd106, 32'd105, 32'd104,
                           32'd102, 32'd101, 32'd100});
        end
        applyStimulus(1'b0, 1'b0, '0, 9'd0);

        $display("[TB] reset mid-frame then fresh stream");
        doReset();
        for (int p = 0; p < 7; p++) applyStimulus(1'b1, 1'b0, EW'(p), 9'd0);
        doReset();
        for (int p = 0; p < 16; p++) applyStimulus(1'b1, 1'b0, EW'(p), 9'd0);

        $display("[TB] start-of-frame resync in mid-frame");
        for (int p = 0; p < 6; p++) applyStimulus(1'b1, 1'b0, EW'(p), 9'd0);
        applyStimulus(1'b1, 1'b1, EW'(50), 9'd0);
        for (int d = 51; d < 66; d++) begin
            applyStimulus(1'b1, 1'b0, EW'(d), 9'd0);
            if (d == 60)
                checkWide("sof_first_taps", rd_data,
                          {32'd60, 32'd59, 32'd58, 32'd56, 32'd55, 32'd54,
                           32'd52, 32'd51, 32'd50});
        end
        applyStimulus(1'b0, 1'b0, '0, 9'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
